// File: rtl/ysyx_25020037_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25020037_rd_arbiter
//  Purpose  : Two-master AXI-style read arbiter (IFU = requester 0, LSU =
//             requester 1) sharing one downstream read port. One outstanding
//             burst at a time; round-robin on ties; sticky burst-length check.
//  Ports    : clk, rst            - clock, async active-high reset
//             m_ar* / m_r*        - upstream per-requester AR/R channels
//             s_ar* / s_r*        - downstream AR/R channel
//             grant               - one-hot current owner, 0 when idle
//             len_err             - sticky burst-length mismatch flag
//  Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020037_rd_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst,
   // upstream AR
   input  logic [1:0]      m_arvalid,
   output logic [1:0]      m_arready,
   input  logic [2*AW-1:0] m_araddr,
   input  logic [15:0]     m_arlen,
   // upstream R
   output logic [1:0]      m_rvalid,
   input  logic [1:0]      m_rready,
   output logic [DW-1:0]   m_rdata,
   output logic [1:0]      m_rresp,
   output logic            m_rlast,
   // downstream AR
   output logic            s_arvalid,
   input  logic            s_arready,
   output logic [AW-1:0]   s_araddr,
   output logic [7:0]      s_arlen,
   // downstream R
   input  logic            s_rvalid,
   output logic            s_rready,
   input  logic [DW-1:0]   s_rdata,
   input  logic [1:0]      s_rresp,
   input  logic            s_rlast,
   // status
   output logic [1:0]      grant,
   output logic            len_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0] state_q, state_d;
   logic       owner_q, owner_d;           // 0 = IFU, 1 = LSU
   logic       last_grant_q, last_grant_d;
   logic [7:0] len_q, len_d;
   logic [7:0] beat_q, beat_d;
   logic       len_err_q, len_err_d;

   // Owner-selected request fields.
   logic          own_arvalid;
   logic [AW-1:0] own_araddr;
   logic [7:0]    own_arlen;
   logic          own_rready;
   logic          r_fire;

   assign own_arvalid = owner_q ? m_arvalid[1]        : m_arvalid[0];
   assign own_araddr  = owner_q ? m_araddr[2*AW-1:AW] : m_araddr[AW-1:0];
   assign own_arlen   = owner_q ? m_arlen[15:8]       : m_arlen[7:0];
   assign own_rready  = owner_q ? m_rready[1]         : m_rready[0];
   // Only meaningful in DATA; the state check keeps stray IDLE/ADDR beats out.
   assign r_fire      = (state_q == ST_DATA) && s_rvalid && own_rready;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b0;
         len_q        <= 8'd0;
         beat_q       <= 8'd0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         len_err_q    <= len_err_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      len_d        = len_q;
      beat_d       = beat_q;
      len_err_d    = len_err_q;
      case (state_q)
         ST_IDLE: begin
            if (|m_arvalid) begin
               state_d = ST_ADDR;
               // On a tie the requester that did not finish last wins.
               if (&m_arvalid) owner_d = ~last_grant_q;
               else            owner_d = m_arvalid[1];
            end
         end
         ST_ADDR: begin
            // Owner withdrew its request: give up without touching
            // last_grant so fairness is unaffected.
            if (!own_arvalid) begin
               state_d = ST_IDLE;
            end else if (s_arready) begin
               state_d = ST_DATA;
               len_d   = own_arlen;
               beat_d  = 8'd0;
            end
         end
         ST_DATA: begin
            if (r_fire) begin
               beat_d = beat_q + 8'd1;
               // beat_q is the number of beats already taken, so the last
               // beat of an arlen=N burst arrives with beat_q == N.
               if (s_rlast) begin
                  if (beat_q != len_q) len_err_d = 1'b1;
                  state_d      = ST_IDLE;
                  last_grant_d = owner_q;
               end else if (beat_q == len_q) begin
                  len_err_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------------
   always_comb begin
      m_arready = 2'b00;
      m_rvalid  = 2'b00;
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      grant     = 2'b00;
      s_araddr  = own_araddr;
      s_arlen   = own_arlen;
      m_rdata   = s_rdata;
      m_rresp   = s_rresp;
      m_rlast   = s_rlast;
      len_err   = len_err_q;
      case (state_q)
         ST_ADDR: begin
            s_arvalid          = own_arvalid;
            m_arready[owner_q] = s_arready;
            grant[owner_q]     = 1'b1;
         end
         ST_DATA: begin
            s_rready          = own_rready;
            m_rvalid[owner_q] = s_rvalid;
            grant[owner_q]    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020037_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25020037_rd_arbiter
//  Purpose  : Directed scoreboard bench for the two-master read arbiter.
//             The stimulus process plays both masters and the slave; a
//             monitor pops expected AR/R transfers as the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020037_rd_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk, rst;
   logic [1:0]      m_arvalid, m_arready, m_rvalid, m_rready, m_rresp, grant;
   logic [2*AW-1:0] m_araddr;
   logic [15:0]     m_arlen;
   logic [DW-1:0]   m_rdata, s_rdata;
   logic            m_rlast, s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, len_err;
   logic [AW-1:0]   s_araddr;
   logic [7:0]      s_arlen;
   logic [1:0]      s_rresp;

   ysyx_25020037_rd_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rlast(m_rlast),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast),
      .grant(grant), .len_err(len_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    id;
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } ar_t;
   typedef struct {
      logic [1:0]    id;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } r_t;

   ar_t ar_q[$];
   r_t  r_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the active edge; outputs are sampled
   // by the monitor on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // All handshake-side outputs and the error flag must be low.
   task automatic check_quiet(input string name);
      check(name, {grant, m_arready, m_rvalid, s_arvalid, s_rready, len_err}, 64'd0);
   endtask

   // ------------------------------------------------------------------------
   // Monitor: pops and compares every AR and R transfer the DUT presents.
   // ------------------------------------------------------------------------
   ar_t mon_ar;
   r_t  mon_r;
   always @(negedge clk) begin
      if (!rst) begin
         if (s_arvalid && s_arready) begin
            if (ar_q.size() == 0) begin
               check("ar_unexpected", 64'd1, 64'd0);
            end else begin
               mon_ar = ar_q.pop_front();
               check("ar_grant", grant, mon_ar.id);
               check("ar_addr", s_araddr, mon_ar.addr);
               check("ar_len", s_arlen, mon_ar.len);
            end
         end
         if (|(m_rvalid & m_rready)) begin
            if (r_q.size() == 0) begin
               check("r_unexpected", 64'd1, 64'd0);
            end else begin
               mon_r = r_q.pop_front();
               check("r_id", m_rvalid & m_rready, mon_r.id);
               check("r_data", m_rdata, mon_r.data);
               check("r_resp", m_rresp, mon_r.resp);
               check("r_last", m_rlast, mon_r.last);
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // One complete transaction for requester `who`, starting in IDLE with
   // the expectation that `who` wins the next arbitration.
   //   nbeats   : rlast is driven on beat nbeats
   //   stall_at : beat index held off by 3 cycles of m_rready low (-1 none)
   //   abort_at : beat index at which reset is asserted instead (-1 none)
   //   hold     : keep m_arvalid[who] high after the AR handshake
   // ------------------------------------------------------------------------
   task automatic burst(input int who, input logic [AW-1:0] addr, input logic [7:0] len,
                        input int nbeats, input int stall_at, input int abort_at,
                        input logic [DW-1:0] base, input bit hold);
      logic [1:0] oh;
      oh = (who == 1) ? 2'b10 : 2'b01;
      m_araddr[who*AW +: AW] = addr;
      m_arlen[who*8 +: 8]    = len;
      m_arvalid[who]         = 1'b1;
      tick();
      check("grant_addr", grant, oh);
      check("s_arvalid", s_arvalid, 1'b1);
      check("s_araddr", s_araddr, addr);
      check("s_arlen", s_arlen, len);
      check("nonowner_arready", m_arready, 2'b00);
      // R traffic during ADDR must not reach any master.
      s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b11;
      #1;
      check("addr_s_rready", s_rready, 1'b0);
      check("addr_m_rvalid", m_rvalid, 2'b00);
      s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b00;
      s_arready = 1'b1;
      ar_q.push_back('{oh, addr, len});
      #1;
      check("m_arready", m_arready, oh);
      tick();
      s_arready = 1'b0;
      if (!hold) m_arvalid[who] = 1'b0;
      #1;
      check("grant_data", grant, oh);
      m_rready[who] = 1'b1;
      for (int k = 0; k < nbeats; k++) begin
         s_rvalid = 1'b1;
         s_rdata  = base + DW'(k);
         s_rresp  = 2'(k);
         s_rlast  = (k == nbeats - 1);
         if (k == abort_at) begin
            s_rlast = 1'b0;
            rst = 1'b1;
            #1;
            check_quiet("reset_mid_data");
            tick();
            rst = 1'b0; s_rvalid = 1'b0; m_rready = 2'b00; m_arvalid = 2'b00;
            return;
         end
         if (k == stall_at) begin
            m_rready[who] = 1'b0;
            repeat (3) begin
               #1;
               check("stall_s_rready", s_rready, 1'b0);
               check("stall_m_rvalid", m_rvalid, oh);
               tick();
            end
            m_rready[who] = 1'b1;
         end
         r_q.push_back('{oh, base + DW'(k), 2'(k), k == nbeats - 1});
         tick();
      end
      s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = 2'b00;
      #1;
      check("grant_idle", grant, 2'b00);
   endtask

   initial begin
      rst = 1'b1;
      m_araddr = '0; m_arlen = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
      // Busy inputs during reset: nothing may leak through.
      m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1'b1; s_rvalid = 1'b1;
      tick(); tick();
      check_quiet("in_reset");
      m_arvalid = 2'b00; m_rready = 2'b00; s_arready = 1'b0; s_rvalid = 1'b0;
      rst = 1'b0;
      #1;
      check_quiet("after_reset");

      // Stray R beat in IDLE is ignored.
      s_rvalid = 1'b1; m_rready = 2'b11;
      #1;
      check("idle_s_rready", s_rready, 1'b0);
      check("idle_m_rvalid", m_rvalid, 2'b00);
      s_rvalid = 1'b0; m_rready = 2'b00;

      // Tie right after reset: LSU first, then IFU with both still held.
      m_arvalid = 2'b11;
      burst(1, 32'h8000_0100, 8'd1, 2, -1, -1, 32'hB000_0000, 1'b1);
      burst(0, 32'h8000_0200, 8'd0, 1, -1, -1, 32'hC000_0000, 1'b0);
      m_arvalid = 2'b00;

      // Single IFU request, len 3, four beats.
      burst(0, 32'h3000_0000, 8'd3, 4, -1, -1, 32'hA000_0000, 1'b0);
      check("len_err_clean1", len_err, 1'b0);

      // LSU backpressure on beat 1.
      burst(1, 32'h4000_0040, 8'd2, 3, 1, -1, 32'hD000_0000, 1'b0);
      check("len_err_clean2", len_err, 1'b0);

      // Reset after 2 of 4 IFU beats (last_grant was LSU before this).
      burst(0, 32'h3000_1000, 8'd3, 4, -1, 2, 32'hE000_0000, 1'b0);
      #1;
      check_quiet("post_abort");
      // last_grant back to 0: LSU wins the tie again.
      m_arvalid = 2'b11;
      burst(1, 32'h5000_0000, 8'd0, 1, -1, -1, 32'h1100_0000, 1'b1);
      burst(0, 32'h5000_0100, 8'd1, 2, -1, -1, 32'h2200_0000, 1'b0);
      m_arvalid = 2'b00;
      burst(1, 32'h5000_0200, 8'd0, 1, -1, -1, 32'h3300_0000, 1'b0);

      // Abandoned IFU AR while last_grant = LSU.
      m_araddr[AW-1:0] = 32'h6000_0000;
      m_arvalid = 2'b01;
      tick();
      check("abandon_grant", grant, 2'b01);
      m_arvalid = 2'b00;
      #1;
      check("abandon_s_arvalid", s_arvalid, 1'b0);
      tick();
      check("abandon_idle", grant, 2'b00);
      // last_grant untouched (LSU), so IFU wins this tie.
      m_arvalid = 2'b11;
      burst(0, 32'h6000_0010, 8'd0, 1, -1, -1, 32'h4400_0000, 1'b1);
      burst(1, 32'h6000_0020, 8'd0, 1, -1, -1, 32'h5500_0000, 1'b0);
      m_arvalid = 2'b00;
      check("len_err_clean3", len_err, 1'b0);

      // Length mismatch: len 1 but rlast on beat 1.
      burst(0, 32'h7000_0000, 8'd1, 1, -1, -1, 32'h6600_0000, 1'b0);
      check("len_err_early_last", len_err, 1'b1);
      burst(1, 32'h7000_0100, 8'd2, 3, -1, -1, 32'h7700_0000, 1'b0);
      check("len_err_sticky", len_err, 1'b1);

      // Reset clears the flag; then a beat at count == len without rlast.
      rst = 1'b1;
      #1;
      check_quiet("reset_clears_err");
      tick();
      rst = 1'b0;
      burst(0, 32'h7000_0200, 8'd0, 2, -1, -1, 32'h8800_0000, 1'b0);
      check("len_err_missing_last", len_err, 1'b1);

      tick();
      check("ar_q_empty", 64'(ar_q.size()), 64'd0);
      check("r_q_empty", 64'(r_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/ysyx_25020037_rd_arbiter.md
YSYX_25020037_RD_ARBITER -- requirements
Module: ysyx_25020037_rd_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning read data width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 m_arvalid  in  2  per-requester AR valid; bit0=IFU, bit1=LSU.
REQ-007 m_arready  out  2  per-requester AR ready.
REQ-008 m_araddr  in  2*AW  packed addresses, requester i at [i*AW +: AW].
REQ-009 m_arlen  in  16  packed burst lengths, requester i at [i*8 +: 8].
REQ-010 m_rvalid  out  2  per-requester R valid.
REQ-011 m_rready  in  2  per-requester R ready.
REQ-012 m_rdata  out  DW  shared R data.
REQ-013 m_rresp  out  2  shared R response.
REQ-014 m_rlast  out  1  shared R last.
REQ-015 s_arvalid / s_arready / s_araddr / s_arlen  out/in/out/out  1/1/AW/8  downstream AR channel.
REQ-016 s_rvalid / s_rready / s_rdata / s_rresp / s_rlast  in/out/in/in/in  1/1/DW/2/1  downstream R channel.
REQ-017 grant  out  2  one-hot current owner; 0 when idle.
REQ-018 len_err  out  1  sticky burst-length mismatch flag.

Function
REQ-019 SHALL implement FSM IDLE, ADDR, DATA.
REQ-020 IDLE: when any m_arvalid is set, SHALL register the owner and go to ADDR next cycle; exactly one cycle of arbitration latency.
REQ-021 Single request: that requester wins.
REQ-022 Both requesting: the requester not equal to last_grant wins (round-robin); last_grant resets to 0, so LSU wins the first tie.
REQ-023 ADDR: s_arvalid=m_arvalid[g]; s_araddr/s_arlen are muxed from owner g; m_arready[g]=s_arready.
REQ-024 On s_arvalid&s_arready, SHALL latch s_arlen into len_q, clear beat counter, and go to DATA.
REQ-025 ADDR: if m_arvalid[g] drops before the handshake (protocol violation), SHALL return to IDLE without updating last_grant.
REQ-026 DATA: s_rready=m_rready[g]; m_rvalid[g]=s_rvalid; m_rdata/m_rresp/m_rlast are passed through from downstream.
REQ-027 DATA: each s_rvalid&s_rready SHALL increment the 8-bit beat counter.
REQ-028 On a beat with s_rlast=1, SHALL go to IDLE and set last_grant=g.
REQ-029 len_err SHALL set if s_rlast arrives with beat count != len_q, or if a beat arrives with count == len_q and s_rlast=0. It stays set until reset.
REQ-030 Non-owner m_arready and m_rvalid SHALL be 0 in all states; in IDLE, all m_arready, m_rvalid, s_arvalid and s_rready SHALL be 0.
REQ-031 Requests arriving during ADDR or DATA SHALL wait; they are evaluated only in IDLE.
REQ-032 A new arbitration SHALL NOT occur in the same cycle as the rlast beat; the earliest re-grant is the cycle after IDLE is entered.
REQ-033 s_rvalid seen in IDLE or ADDR SHALL be ignored: s_rready=0, no counting.
REQ-034 grant SHALL equal the one-hot owner in ADDR and DATA, and 0 in IDLE.

Reset
REQ-035 On rst assertion, at any time including mid-burst, the FSM SHALL go to IDLE, with last_grant=0, grant=0, len_err=0, beat counter=0, len_q=0.
REQ-036 While in reset, all valid/ready outputs SHALL be 0; data outputs are don't-care.
REQ-037 After rst deasserts, the first arbitration SHALL occur on the first rising edge with any m_arvalid set.

Verification
REQ-038 Single IFU request: m_arvalid=01, addr 0x3000_0000, len 3; slave gives 4 beats, last on beat 4 -> grant=01 one cycle after request, 4 m_rvalid[0] pulses, IDLE after last beat, len_err=0.
REQ-039 Simultaneous requests after reset, m_arvalid=11 held -> LSU granted first (grant=10); after its rlast, IFU granted (grant=01) with no intervening LSU grant.
REQ-040 Length mismatch: len=1, slave asserts rlast on beat 1 -> len_err=1, FSM returns to IDLE, and len_err stays 1 after further clean bursts.
REQ-041 Backpressure: m_rready[1]=0 for 3 cycles with s_rvalid=1 -> s_rready=0 for those cycles, beat count unchanged, data delivered once ready rises.
REQ-042 Reset mid-DATA after 2 of 4 beats -> all outputs 0 immediately; after release, a new IFU request is granted normally with last_grant=0 tie behavior.
REQ-043 Abandoned AR: the owner drops arvalid in ADDR before s_arready -> IDLE next cycle, grant=0, and the next tie still follows the old last_grant.
